// File: rtl/sram_arbiter.sv
// sram_arbiter: timed access sequencer for the single 8-bit external SRAM port,
// shared between the ROM/initial loader (write only) and the core memory bus.
//
// Each access runs IDLE -> ADDR (1) -> ACCESS (WS) -> DONE (1) -> IDLE.
// Requests are rising edges; each requester keeps one latched request plus a
// pending flag. Core has priority, but after two consecutive core grants with
// the loader waiting, the loader gets the next slot.
//
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   iniW/iniA/iniD, iniAck   loader write request (edge) and completion pulse
//   memRd/memWr/memA/memD    core request (edge), write wins on a tie
//   memQ, memAck             read data register and completion pulse
//   overrun                  sticky: a pending request was overwritten
//   sramOe/sramWe            active-low strobes
//   sramA/sramDo/sramDe      address, write data, write-drive enable
//   sramDi                   read data from the pins
module sram_arbiter #(
    parameter int AW = 19,
    parameter int WS = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniW,
    input  logic [AW-1:0] iniA,
    input  logic [7:0]    iniD,
    output logic          iniAck,
    input  logic          memRd,
    input  logic          memWr,
    input  logic [AW-1:0] memA,
    input  logic [7:0]    memD,
    output logic [7:0]    memQ,
    output logic          memAck,
    output logic          overrun,
    output logic          sramOe,
    output logic          sramWe,
    output logic [20:0]   sramA,
    output logic [7:0]    sramDo,
    output logic          sramDe,
    input  logic [7:0]    sramDi
);

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } req_t;

    typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WS - 1);

    state_t     state, state_nxt;
    logic       ini_q, rd_q, wr_q;
    logic       ini_edge, mem_edge, mem_wr_edge;
    logic       ini_pend, mem_pend;
    logic       ini_renew, mem_renew;
    logic       core_req, ini_req, core_busy, ini_busy;
    logic       gnt_core, gnt_ini;
    req_t       ini_lat, mem_lat, ini_sel, mem_sel, gnt_req, act;
    logic       act_core;
    logic [1:0] fair;
    logic [3:0] cnt;
    logic [7:0] do_q;

    // Edge detectors; history regs reset to 1 so a level held across reset
    // is not mistaken for a new request.
    assign ini_edge    = iniW & ~ini_q;
    assign mem_wr_edge = memWr & ~wr_q;
    assign mem_edge    = mem_wr_edge | (memRd & ~rd_q);

    // Edge bypass: a same-cycle edge is granted with its live inputs.
    assign ini_sel = ini_edge ? req_t'{wr: 1'b1, addr: iniA, data: iniD} : ini_lat;
    assign mem_sel = mem_edge ? req_t'{wr: mem_wr_edge, addr: memA, data: memD} : mem_lat;

    assign core_req  = mem_pend | mem_edge;
    assign ini_req   = ini_pend | ini_edge;
    assign core_busy = (state != IDLE) && act_core;
    assign ini_busy  = (state != IDLE) && !act_core;

    assign sramA  = 21'(act.addr);
    assign sramDo = do_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt_core  = 1'b0;
        gnt_ini   = 1'b0;
        case (state)
            IDLE: begin
                if (core_req && !(ini_req && fair == 2'd2)) begin
                    gnt_core  = 1'b1;
                    state_nxt = ADDR;
                end else if (ini_req) begin
                    gnt_ini   = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR:    state_nxt = ACCESS;
            ACCESS:  if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        gnt_req = gnt_core ? mem_sel : ini_sel;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ini_q     <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            ini_pend  <= 1'b0;
            mem_pend  <= 1'b0;
            ini_renew <= 1'b0;
            mem_renew <= 1'b0;
            ini_lat   <= '0;
            mem_lat   <= '0;
            act       <= '0;
            act_core  <= 1'b0;
            fair      <= 2'd0;
            cnt       <= 4'd0;
            do_q      <= 8'h00;
            overrun   <= 1'b0;
            sramOe    <= 1'b1;
            sramWe    <= 1'b1;
            sramDe    <= 1'b0;
            memQ      <= 8'h00;
            memAck    <= 1'b0;
            iniAck    <= 1'b0;
        end else begin
            ini_q <= iniW;
            rd_q  <= memRd;
            wr_q  <= memWr;

            if (state == ADDR)        cnt <= 4'd0;
            else if (state == ACCESS) cnt <= cnt + 4'd1;

            // The granted request is copied so a newer edge can refill the
            // latch without disturbing the access in flight.
            if (gnt_core || gnt_ini) begin
                act      <= gnt_req;
                act_core <= gnt_core;
                if (gnt_req.wr) do_q <= gnt_req.data;
            end

            if (gnt_ini)       fair <= 2'd0;
            else if (gnt_core) fair <= ini_req ? fair + 2'd1 : 2'd0;

            // Core request slot. An edge while that requester is in service is
            // a fresh request (renew) and must survive the DONE clear; an edge
            // on a pending request that is not yet in service overwrites it.
            if (gnt_core) mem_renew <= 1'b0;
            if (mem_edge) begin
                mem_lat  <= mem_sel;
                mem_pend <= 1'b1;
                if (core_busy)     mem_renew <= 1'b1;
                else if (mem_pend) overrun   <= 1'b1;
            end else if (state == DONE && act_core && !mem_renew) begin
                mem_pend <= 1'b0;
            end

            // Loader request slot, same rules.
            if (gnt_ini) ini_renew <= 1'b0;
            if (ini_edge) begin
                ini_lat  <= ini_sel;
                ini_pend <= 1'b1;
                if (ini_busy)      ini_renew <= 1'b1;
                else if (ini_pend) overrun   <= 1'b1;
            end else if (state == DONE && !act_core && !ini_renew) begin
                ini_pend <= 1'b0;
            end

            // Pin outputs are registered from the next state so strobes are
            // glitch-free. Write data drive spans ADDR..DONE for hold time.
            sramOe <= !(state_nxt == ACCESS && !act.wr);
            sramWe <= !(state_nxt == ACCESS && act.wr);
            if (state_nxt == ADDR)
                sramDe <= gnt_req.wr;
            else if (state_nxt == ACCESS || state_nxt == DONE)
                sramDe <= act.wr;
            else
                sramDe <= 1'b0;

            if (state == ACCESS && cnt == LAST && !act.wr) memQ <= sramDi;

            memAck <= (state_nxt == DONE) && act_core;
            iniAck <= (state_nxt == DONE) && !act_core;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized
// single-access run checked against a behavioural memory/ordering model.
module tb_sram_arbiter;
    localparam int AW = 19;
    localparam int WS = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iniW = 1'b0, memRd = 1'b0, memWr = 1'b0;
    logic [AW-1:0] iniA = '0, memA = '0;
    logic [7:0]    iniD = 8'h00, memD = 8'h00;
    logic          iniAck, memAck, overrun, sramOe, sramWe, sramDe;
    logic [7:0]    memQ, sramDo, sramDi;
    logic [20:0]   sramA;

    logic [7:0] di_ovr = 8'h00;
    logic       di_ovr_en = 1'b0;
    logic [7:0] model_q = 8'h00;
    assign sramDi = di_ovr_en ? di_ovr : model_q;

    sram_arbiter #(.AW(AW), .WS(WS)) dut (
        .clock(clock), .reset(reset),
        .iniW(iniW), .iniA(iniA), .iniD(iniD), .iniAck(iniAck),
        .memRd(memRd), .memWr(memWr), .memA(memA), .memD(memD),
        .memQ(memQ), .memAck(memAck), .overrun(overrun),
        .sramOe(sramOe), .sramWe(sramWe), .sramA(sramA),
        .sramDo(sramDo), .sramDe(sramDe), .sramDi(sramDi)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    always @(posedge clock) cyc_n <= cyc_n + 1;

    // Pin-level SRAM device and event recorder.
    logic [7:0]  smem [int];
    logic [21:0] ack_log [$];   // {core?, sramA} per ack
    int          ack_cyc [$];
    int          oe_runs [$], we_runs [$], de_runs [$];
    int          oe_run = 0, we_run = 0, de_run = 0;

    always @(negedge clock) begin
        if (!sramWe) smem[int'(sramA)] = sramDo;
        model_q = smem.exists(int'(sramA)) ? smem[int'(sramA)] : 8'h00;
        if (memAck) begin ack_log.push_back({1'b1, sramA}); ack_cyc.push_back(cyc_n); end
        if (iniAck) begin ack_log.push_back({1'b0, sramA}); ack_cyc.push_back(cyc_n); end
        if (!sramOe) oe_run++; else if (oe_run != 0) begin oe_runs.push_back(oe_run); oe_run = 0; end
        if (!sramWe) we_run++; else if (we_run != 0) begin we_runs.push_back(we_run); we_run = 0; end
        if (sramDe)  de_run++; else if (de_run != 0) begin de_runs.push_back(de_run); de_run = 0; end
    end

    // Reference model: intended memory contents and expected memQ.
    logic [7:0] ref_mem [int];
    logic [7:0] ref_q = 8'h00;

    function automatic logic [7:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic step(int n);
        repeat (n) begin @(negedge clock); #1; end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(3);
        n_cmp++; if (sramOe !== 1'b1)     begin n_bad++; $display("FAIL reset_oe: got %b want 1", sramOe); end
        n_cmp++; if (sramWe !== 1'b1)     begin n_bad++; $display("FAIL reset_we: got %b want 1", sramWe); end
        n_cmp++; if (sramDe !== 1'b0)     begin n_bad++; $display("FAIL reset_de: got %b want 0", sramDe); end
        n_cmp++; if (sramA !== 21'h0)     begin n_bad++; $display("FAIL reset_a: got %h want 0", sramA); end
        n_cmp++; if (sramDo !== 8'h00)    begin n_bad++; $display("FAIL reset_do: got %h want 0", sramDo); end
        n_cmp++; if (memQ !== 8'h00)      begin n_bad++; $display("FAIL reset_memq: got %h want 0", memQ); end
        n_cmp++; if (memAck !== 1'b0)     begin n_bad++; $display("FAIL reset_memack: got %b want 0", memAck); end
        n_cmp++; if (iniAck !== 1'b0)     begin n_bad++; $display("FAIL reset_iniack: got %b want 0", iniAck); end
        n_cmp++; if (overrun !== 1'b0)    begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        reset = 1'b0;
        ref_q = 8'h00;
        step(2);
    endtask

    task automatic test_core_read;
        int b_ack = ack_log.size();
        int b_oe  = oe_runs.size();
        int t0;
        di_ovr = 8'hA5; di_ovr_en = 1'b1;
        memA = 19'h12345; memRd = 1'b1; t0 = cyc_n;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (i == 1) begin
                memRd = 1'b0;
                n_cmp++; if (sramA !== 21'h012345) begin n_bad++; $display("FAIL rd_addr: got %h want 012345", sramA); end
                n_cmp++; if (sramOe !== 1'b1)      begin n_bad++; $display("FAIL rd_oe_setup: got %b want 1", sramOe); end
            end
            if (i == 2 || i == 3) begin
                n_cmp++; if (sramOe !== 1'b0) begin n_bad++; $display("FAIL rd_oe_strobe c%0d: got %b want 0", i, sramOe); end
            end
            if (i == WS + 2) begin
                n_cmp++; if (memAck !== 1'b1) begin n_bad++; $display("FAIL rd_ack: got %b want 1", memAck); end
                n_cmp++; if (memQ !== 8'hA5)  begin n_bad++; $display("FAIL rd_data: got %h want a5", memQ); end
            end
            if (i == WS + 3) begin
                n_cmp++; if (memAck !== 1'b0) begin n_bad++; $display("FAIL rd_ack_pulse: got %b want 0", memAck); end
            end
        end
        di_ovr_en = 1'b0;
        ref_q = 8'hA5;
        n_cmp++; if (oe_runs.size() != b_oe + 1 || oe_runs[b_oe] != WS)
            begin n_bad++; $display("FAIL rd_oe_width: runs %0d want 1 of width %0d", oe_runs.size() - b_oe, WS); end
        n_cmp++; if (ack_log.size() != b_ack + 1 || ack_cyc[b_ack] != t0 + WS + 2)
            begin n_bad++; $display("FAIL rd_latency: acks %0d want 1 at cycle %0d", ack_log.size() - b_ack, t0 + WS + 2); end
    endtask

    task automatic test_core_write;
        int b_ack = ack_log.size();
        int b_we  = we_runs.size();
        int b_de  = de_runs.size();
        memA = 19'h00100; memD = 8'h3C; memWr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (i == 1) begin
                memWr = 1'b0;
                n_cmp++; if (sramDe !== 1'b1 || sramWe !== 1'b1) begin n_bad++; $display("FAIL wr_setup: de %b we %b want 1 1", sramDe, sramWe); end
                n_cmp++; if (sramDo !== 8'h3C || sramA !== 21'h000100) begin n_bad++; $display("FAIL wr_bus: do %h a %h want 3c 000100", sramDo, sramA); end
            end
            if (i == WS + 2) begin
                n_cmp++; if (memAck !== 1'b1) begin n_bad++; $display("FAIL wr_ack: got %b want 1", memAck); end
                n_cmp++; if (sramDe !== 1'b1 || sramWe !== 1'b1 || sramDo !== 8'h3C || sramA !== 21'h000100)
                    begin n_bad++; $display("FAIL wr_hold: de %b we %b do %h a %h", sramDe, sramWe, sramDo, sramA); end
            end
            if (i == WS + 3) begin
                n_cmp++; if (sramDe !== 1'b0 || memAck !== 1'b0) begin n_bad++; $display("FAIL wr_release: de %b ack %b want 0 0", sramDe, memAck); end
            end
        end
        ref_mem[32'h100] = 8'h3C;
        n_cmp++; if (we_runs.size() != b_we + 1 || we_runs[b_we] != WS)
            begin n_bad++; $display("FAIL wr_we_width: runs %0d want 1 of width %0d", we_runs.size() - b_we, WS); end
        n_cmp++; if (de_runs.size() != b_de + 1 || de_runs[b_de] != WS + 2)
            begin n_bad++; $display("FAIL wr_de_width: runs %0d want 1 of width %0d", de_runs.size() - b_de, WS + 2); end
        n_cmp++; if (ack_log.size() != b_ack + 1) begin n_bad++; $display("FAIL wr_ack_count: got %0d want 1", ack_log.size() - b_ack); end
        n_cmp++; if (memQ !== ref_q) begin n_bad++; $display("FAIL wr_memq_kept: got %h want %h", memQ, ref_q); end
    endtask

    task automatic test_simultaneous;
        int b = ack_log.size();
        int t0;
        iniA = 19'h05555; iniD = 8'hE1; iniW = 1'b1;
        memA = 19'h00300; memD = 8'h7E; memWr = 1'b1; t0 = cyc_n;
        step(1);
        iniW = 1'b0; memWr = 1'b0;
        step(13);
        ref_mem[32'h300] = 8'h7E;
        ref_mem[32'h5555] = 8'hE1;
        n_cmp++; if (ack_log.size() != b + 2) begin n_bad++; $display("FAIL sim_count: got %0d want 2", ack_log.size() - b); end
        else begin
            n_cmp++; if (ack_log[b] !== {1'b1, 21'h000300}) begin n_bad++; $display("FAIL sim_first: got %h want core 000300", ack_log[b]); end
            n_cmp++; if (ack_log[b+1] !== {1'b0, 21'h005555}) begin n_bad++; $display("FAIL sim_second: got %h want ini 005555", ack_log[b+1]); end
            n_cmp++; if (ack_cyc[b] != t0 + WS + 2 || ack_cyc[b+1] - ack_cyc[b] != WS + 3)
                begin n_bad++; $display("FAIL sim_spacing: acks at %0d,%0d want %0d,%0d", ack_cyc[b], ack_cyc[b+1], t0 + WS + 2, t0 + 2*WS + 5); end
        end
    endtask

    task automatic test_fairness;
        int b = ack_log.size();
        logic [21:0] exp_log [4];
        exp_log[0] = {1'b1, 21'h000001};
        exp_log[1] = {1'b1, 21'h000002};
        exp_log[2] = {1'b0, 21'h00AAAA};
        exp_log[3] = {1'b1, 21'h000003};
        iniA = 19'h0AAAA; iniD = 8'h11; iniW = 1'b1;
        memA = 19'h1; memRd = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            if (i == 1) begin iniW = 1'b0; memRd = 1'b0; end
            if (i == 2) begin memA = 19'h2; memRd = 1'b1; end
            if (i == 3) memRd = 1'b0;
            if (i == 7) begin memA = 19'h3; memRd = 1'b1; end
            if (i == 8) memRd = 1'b0;
        end
        ref_mem[32'hAAAA] = 8'h11;
        ref_q = ref_rd(3);
        n_cmp++; if (ack_log.size() != b + 4) begin n_bad++; $display("FAIL fair_count: got %0d want 4", ack_log.size() - b); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (b + k >= ack_log.size() || ack_log[b+k] !== exp_log[k])
                begin n_bad++; $display("FAIL fair_order[%0d]: want %h", k, exp_log[k]); end
        end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL fair_overrun: got %b want 0", overrun); end
        n_cmp++; if (memQ !== ref_q)   begin n_bad++; $display("FAIL fair_memq: got %h want %h", memQ, ref_q); end
    endtask

    task automatic test_overrun;
        int b = ack_log.size();
        iniA = 19'h00777; iniD = 8'h22; iniW = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step(1);
            if (i == 1) begin iniW = 1'b0; memA = 19'h1; memRd = 1'b1; end
            if (i == 2) memRd = 1'b0;
            if (i == 3) begin memA = 19'h2; memRd = 1'b1; end
            if (i == 4) memRd = 1'b0;
        end
        ref_mem[32'h777] = 8'h22;
        ref_q = ref_rd(2);
        n_cmp++; if (ack_log.size() != b + 2) begin n_bad++; $display("FAIL ovr_count: got %0d want 2", ack_log.size() - b); end
        else begin
            n_cmp++; if (ack_log[b] !== {1'b0, 21'h000777}) begin n_bad++; $display("FAIL ovr_loader: got %h want ini 000777", ack_log[b]); end
            n_cmp++; if (ack_log[b+1] !== {1'b1, 21'h000002}) begin n_bad++; $display("FAIL ovr_core: got %h want core 000002", ack_log[b+1]); end
        end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        n_cmp++; if (memQ !== ref_q)   begin n_bad++; $display("FAIL ovr_memq: got %h want %h", memQ, ref_q); end
    endtask

    task automatic test_reset_mid;
        int b, b_oe, b_we, t0;
        b = ack_log.size(); b_oe = oe_runs.size(); b_we = we_runs.size();
        memA = 19'h00200; memD = 8'h5A; memWr = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (i == 1) memWr = 1'b0;
            if (i == 2) begin
                n_cmp++; if (sramWe !== 1'b0) begin n_bad++; $display("FAIL rst_pre_we: got %b want 0", sramWe); end
                reset = 1'b1; memA = 19'h00100; memRd = 1'b1;
            end
            if (i == 3) begin
                n_cmp++; if (sramWe !== 1'b1 || sramDe !== 1'b0 || sramOe !== 1'b1)
                    begin n_bad++; $display("FAIL rst_pins: we %b de %b oe %b want 1 0 1", sramWe, sramDe, sramOe); end
                n_cmp++; if (memAck !== 1'b0 || overrun !== 1'b0)
                    begin n_bad++; $display("FAIL rst_flags: ack %b overrun %b want 0 0", memAck, overrun); end
            end
            if (i == 4) reset = 1'b0;
        end
        ref_q = 8'h00;
        n_cmp++; if (ack_log.size() != b) begin n_bad++; $display("FAIL rst_no_ack: got %0d acks want 0", ack_log.size() - b); end
        n_cmp++; if (oe_runs.size() != b_oe || we_runs.size() != b_we + 1)
            begin n_bad++; $display("FAIL rst_no_access: oe runs %0d we runs %0d want 0 1", oe_runs.size() - b_oe, we_runs.size() - b_we); end
        memRd = 1'b0;
        step(1);
        memRd = 1'b1; t0 = cyc_n;
        step(1);
        memRd = 1'b0;
        step(7);
        ref_q = ref_rd(32'h100);
        n_cmp++; if (ack_log.size() != b + 1 || ack_log[b] !== {1'b1, 21'h000100} || ack_cyc[b] != t0 + WS + 2)
            begin n_bad++; $display("FAIL rst_retoggle: acks %0d want 1 core read of 000100", ack_log.size() - b); end
        n_cmp++; if (memQ !== ref_q) begin n_bad++; $display("FAIL rst_memq: got %h want %h", memQ, ref_q); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 16; it++) begin
            int b = ack_log.size();
            int t0;
            logic          core = 1'($urandom_range(0, 1));
            logic          wr   = core ? 1'($urandom_range(0, 1)) : 1'b1;
            logic [AW-1:0] a    = 19'h40000 + 19'($urandom_range(0, 7));
            logic [7:0]    d    = 8'($urandom_range(0, 255));
            if (core) begin
                memA = a; memD = d;
                if (wr) memWr = 1'b1; else memRd = 1'b1;
            end else begin
                iniA = a; iniD = d; iniW = 1'b1;
            end
            t0 = cyc_n;
            step(1);
            memWr = 1'b0; memRd = 1'b0; iniW = 1'b0;
            for (int k = 0; k < 20 && ack_log.size() == b; k++) step(1);
            if (wr) ref_mem[int'(a)] = d;
            else    ref_q = ref_rd(int'(a));
            n_cmp++;
            if (ack_log.size() == b) begin
                n_bad++; $display("FAIL rnd%0d_timeout: no ack within 20 cycles", it);
            end else if (ack_log[b] !== {core, 21'(a)} || ack_cyc[b] != t0 + WS + 2) begin
                n_bad++; $display("FAIL rnd%0d_ack: got %h at %0d want %h at %0d", it, ack_log[b], ack_cyc[b], {core, 21'(a)}, t0 + WS + 2);
            end
            n_cmp++; if (memQ !== ref_q) begin n_bad++; $display("FAIL rnd%0d_memq: got %h want %h", it, memQ, ref_q); end
            step($urandom_range(1, 3));
        end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rnd_overrun: got %b want 0", overrun); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_core_read();
        test_core_write();
        test_simultaneous();
        test_fairness();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
